lab5_idex_stage: RTL and testbench
==================================

LAB5_IDEX_STAGE -- requirements
Module: lab5_idex_stage

Interface
REQ-001 Parameter: CNT_W, 32, width of the load-use stall counter.
REQ-002 clk  input  1  single clock, all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 id_valid  input  1  decode stage holds a real instruction.
REQ-005 rd1, rd2  input  32  register-file read data for the decode instruction, bypass already applied.
REQ-006 imm  input  32  sign-/zero-extended immediate.
REQ-007 rs, rt, wa  input  5  source register indices and destination index.
REQ-008 uses_rt  input  1  the instruction reads rt as a source.
REQ-009 regwrite, memread, memwrite, alusrc  input  1 each  decode control bits.
REQ-010 alu_op  input  4  ALU operation code.
REQ-011 flush  input  1  squash the instruction entering EX (branch/jump redirect).
REQ-012 ex_hold  input  1  EX stage busy; the EX register must not advance.
REQ-013 ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc  output  1 each  registered copies.
REQ-014 ex_rd1, ex_rd2, ex_imm  output  32  registered operands.
REQ-015 ex_rs, ex_rt, ex_wa  output  5  registered indices.
REQ-016 ex_alu_op  output  4  registered ALU op.
REQ-017 id_stall  output  1  combinational; freezes PC and IF/ID register.
REQ-018 stall_count  output  CNT_W  count of load-use stall cycles.

Function
REQ-019 Load-use hazard (lu) SHALL be: ex_valid & ex_memread & (ex_wa != 0) & id_valid & ((ex_wa == rs) | (uses_rt & (ex_wa == rt))).
REQ-020 id_stall SHALL equal ex_hold | (lu & ~flush).
REQ-021 Per-edge update priority SHALL be: flush > ex_hold > lu > normal load.
REQ-022 flush: ex_valid, ex_regwrite, ex_memread and ex_memwrite SHALL clear to 0 at the next edge; other fields SHALL be don't-care; flush overrides a simultaneous ex_hold.
REQ-023 ex_hold (no flush): every EX output SHALL keep its value.
REQ-024 lu (no flush, no hold): a bubble SHALL be inserted (same clearing as REQ-022) while the decode instruction is held upstream via id_stall.
REQ-025 Normal: all inputs SHALL be captured, with ex_valid = id_valid; control bits SHALL be forced to 0 when id_valid = 0.
REQ-026 Latency SHALL be exactly one clock from decode inputs to EX outputs; no combinational input-to-EX-output path.
REQ-027 FSM states: RUN, LU_BUBBLE; RUN->LU_BUBBLE on an edge where lu is taken (REQ-024); LU_BUBBLE->RUN unconditionally at the next edge; flush in any state forces RUN.
REQ-028 In LU_BUBBLE, lu SHALL evaluate false by construction (ex_memread = 0), so a load-use stall SHALL last exactly one cycle.
REQ-029 stall_count SHALL increment by 1 on each edge where the lu path of REQ-024 is taken, and SHALL saturate at all-ones without wrapping.
REQ-030 A destination index of 0 SHALL never cause a stall.

Reset
REQ-031 On rst assertion, without waiting for clk: all EX outputs SHALL be 0, the FSM SHALL be in RUN, and stall_count SHALL be 0.
REQ-032 id_stall SHALL be 0 while rst is high.
REQ-033 The first capture after rst deassertion SHALL occur at the first following posedge.

Structure
REQ-034 Shared package: ALU op width (4), register-index width (5), data width (32), and FSM state encoding constants.
REQ-035 One sub-module, lab5_hazard_detect, SHALL hold the combinational lu logic of REQ-019; the pipeline register, FSM and counter SHALL stay in lab5_idex_stage.

Verification
REQ-036 Normal capture: id_valid=1, rd1=0x11, rd2=0x22, wa=5, regwrite=1 -> next edge ex_valid=1, ex_rd1=0x11, ex_rd2=0x22, ex_wa=5, id_stall=0.
REQ-037 Load-use: EX holds lw (memread=1, wa=8); ID has rs=8 -> id_stall=1 for one cycle, a bubble is inserted (ex_valid=0), stall_count=1, then the instruction is captured on the following edge.
REQ-038 rt case: EX lw wa=9; ID rt=9 with uses_rt=0 -> no stall; same with uses_rt=1 -> stall. EX lw wa=0 with ID rs=0 -> no stall.
REQ-039 flush and ex_hold asserted together with a valid ID instruction -> next edge ex_valid=0, all control bits 0.
REQ-040 ex_hold=1 for 3 cycles -> EX outputs unchanged, id_stall=1 throughout, stall_count unchanged.
REQ-041 Reset mid-stall: assert rst between edges during LU_BUBBLE -> outputs 0 immediately, state RUN, stall_count=0; with CNT_W=4 forced to 15, a further lu leaves stall_count at 15.

Source files
------------

// File: rtl/lab5_idex_stage_pkg.sv
// Shared widths, EX pipeline register layout and FSM encoding for the ID/EX stage.
package lab5_idex_stage_pkg;

    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic {
        StRun      = 1'b0,
        StLuBubble = 1'b1
    } state_e;

    typedef struct packed {
        logic                valid;
        logic                regwrite;
        logic                memread;
        logic                memwrite;
        logic                alusrc;
        logic [ALU_OP_W-1:0] alu_op;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    wa;
        logic [DATA_W-1:0]   rd1;
        logic [DATA_W-1:0]   rd2;
        logic [DATA_W-1:0]   imm;
    } idex_t;

endpackage

// File: rtl/lab5_idex_stage_if.sv
// Decode-to-EX bundle: the decode side is the master, the ID/EX stage is the slave.
interface lab5_idex_stage_if
    import lab5_idex_stage_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic                id_valid;
    logic [DATA_W-1:0]   rd1;
    logic [DATA_W-1:0]   rd2;
    logic [DATA_W-1:0]   imm;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    wa;
    logic                uses_rt;
    logic                regwrite;
    logic                memread;
    logic                memwrite;
    logic                alusrc;
    logic [ALU_OP_W-1:0] alu_op;
    logic                flush;
    logic                ex_hold;

    logic                ex_valid;
    logic                ex_regwrite;
    logic                ex_memread;
    logic                ex_memwrite;
    logic                ex_alusrc;
    logic [DATA_W-1:0]   ex_rd1;
    logic [DATA_W-1:0]   ex_rd2;
    logic [DATA_W-1:0]   ex_imm;
    logic [REG_W-1:0]    ex_rs;
    logic [REG_W-1:0]    ex_rt;
    logic [REG_W-1:0]    ex_wa;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic                id_stall;
    logic [CNT_W-1:0]    stall_count;

    modport master (
        output id_valid, rd1, rd2, imm, rs, rt, wa, uses_rt,
               regwrite, memread, memwrite, alusrc, alu_op, flush, ex_hold,
        input  ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc,
               ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_wa, ex_alu_op,
               id_stall, stall_count
    );

    modport slave (
        input  id_valid, rd1, rd2, imm, rs, rt, wa, uses_rt,
               regwrite, memread, memwrite, alusrc, alu_op, flush, ex_hold,
        output ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc,
               ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_wa, ex_alu_op,
               id_stall, stall_count
    );

endinterface

// File: rtl/lab5_hazard_detect.sv
// Load-use hazard: the load in EX writes a register the decode instruction reads.
module lab5_hazard_detect
    import lab5_idex_stage_pkg::*;
(
    input  logic             i_ex_valid,
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_wa,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rt,
    input  logic             i_uses_rt,
    output logic             o_lu
);

    logic w_src_match;

    assign w_src_match = (i_ex_wa == i_rs) | (i_uses_rt & (i_ex_wa == i_rt));

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign o_lu = i_ex_valid & i_ex_memread & (i_ex_wa != '0) & i_id_valid & w_src_match;

endmodule

// File: rtl/lab5_idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold control
// and a saturating count of load-use stall cycles.
module lab5_idex_stage
    import lab5_idex_stage_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    lab5_idex_stage_if.slave bus
);

    idex_t            r_ex;
    idex_t            w_ex_load;
    idex_t            w_ex_bubble;
    state_e           r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_lu_raw;
    logic             w_lu;

    lab5_hazard_detect u_hazard (
        .i_ex_valid   (r_ex.valid),
        .i_ex_memread (r_ex.memread),
        .i_ex_wa      (r_ex.wa),
        .i_id_valid   (bus.id_valid),
        .i_rs         (bus.rs),
        .i_rt         (bus.rt),
        .i_uses_rt    (bus.uses_rt),
        .o_lu         (w_lu_raw)
    );

    // A bubble already has memread cleared; the state gate keeps that explicit.
    assign w_lu = w_lu_raw & (r_state == StRun);

    always_comb begin
        w_ex_load          = r_ex;
        w_ex_load.valid    = bus.id_valid;
        w_ex_load.regwrite = bus.regwrite & bus.id_valid;
        w_ex_load.memread  = bus.memread & bus.id_valid;
        w_ex_load.memwrite = bus.memwrite & bus.id_valid;
        w_ex_load.alusrc   = bus.alusrc & bus.id_valid;
        w_ex_load.alu_op   = bus.alu_op;
        w_ex_load.rs       = bus.rs;
        w_ex_load.rt       = bus.rt;
        w_ex_load.wa       = bus.wa;
        w_ex_load.rd1      = bus.rd1;
        w_ex_load.rd2      = bus.rd2;
        w_ex_load.imm      = bus.imm;
    end

    // Bubbles keep the operand fields and only kill the control bits.
    always_comb begin
        w_ex_bubble          = r_ex;
        w_ex_bubble.valid    = 1'b0;
        w_ex_bubble.regwrite = 1'b0;
        w_ex_bubble.memread  = 1'b0;
        w_ex_bubble.memwrite = 1'b0;
        w_ex_bubble.alusrc   = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex        <= '0;
            r_state     <= StRun;
            r_stall_cnt <= '0;
        end else begin
            r_state <= StRun;
            if (bus.flush) begin
                r_ex <= w_ex_bubble;
            end else if (bus.ex_hold) begin
                r_ex <= r_ex;
            end else if (w_lu) begin
                r_ex    <= w_ex_bubble;
                r_state <= StLuBubble;
                if (r_stall_cnt != '1) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
            end else begin
                r_ex <= w_ex_load;
            end
        end
    end

    assign bus.id_stall    = ~rst & (bus.ex_hold | (w_lu & ~bus.flush));
    assign bus.stall_count = r_stall_cnt;

    assign bus.ex_valid    = r_ex.valid;
    assign bus.ex_regwrite = r_ex.regwrite;
    assign bus.ex_memread  = r_ex.memread;
    assign bus.ex_memwrite = r_ex.memwrite;
    assign bus.ex_alusrc   = r_ex.alusrc;
    assign bus.ex_alu_op   = r_ex.alu_op;
    assign bus.ex_rs       = r_ex.rs;
    assign bus.ex_rt       = r_ex.rt;
    assign bus.ex_wa       = r_ex.wa;
    assign bus.ex_rd1      = r_ex.rd1;
    assign bus.ex_rd2      = r_ex.rd2;
    assign bus.ex_imm      = r_ex.imm;

endmodule

// File: tb/tb_lab5_idex_stage.sv
// Directed and random checks of the ID/EX stage against an instruction-level model.
module tb_lab5_idex_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lab5_idex_stage_if #(.CNT_W(32)) bus ();
    lab5_idex_stage_if #(.CNT_W(4))  bus4 ();

    lab5_idex_stage #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    lab5_idex_stage #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the instruction sitting in EX
    bit          m_valid, m_regwrite, m_memread, m_memwrite, m_alusrc;
    logic [3:0]  m_alu_op;
    logic [4:0]  m_rs, m_rt, m_wa;
    logic [31:0] m_rd1, m_rd2, m_imm;
    longint      m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_regwrite = 0; m_memread = 0; m_memwrite = 0; m_alusrc = 0;
        m_alu_op = '0; m_rs = '0; m_rt = '0; m_wa = '0;
        m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_cnt = 0;
    endtask

    task automatic model_kill();
        m_valid = 0; m_regwrite = 0; m_memread = 0; m_memwrite = 0; m_alusrc = 0;
    endtask

    function automatic bit model_lu();
        bit dep;
        dep = (m_wa == bus.rs) || (bus.uses_rt && (m_wa == bus.rt));
        return m_valid && m_memread && (m_wa != 0) && bus.id_valid && dep;
    endfunction

    task automatic compare_all(input string tg);
        chk({tg, ".ex_valid"}, 32'(bus.ex_valid), 32'(m_valid));
        chk({tg, ".ex_regwrite"}, 32'(bus.ex_regwrite), 32'(m_regwrite));
        chk({tg, ".ex_memread"}, 32'(bus.ex_memread), 32'(m_memread));
        chk({tg, ".ex_memwrite"}, 32'(bus.ex_memwrite), 32'(m_memwrite));
        chk({tg, ".stall_count"}, bus.stall_count, 32'(m_cnt));
        if (m_valid) begin
            chk({tg, ".ex_alusrc"}, 32'(bus.ex_alusrc), 32'(m_alusrc));
            chk({tg, ".ex_alu_op"}, 32'(bus.ex_alu_op), 32'(m_alu_op));
            chk({tg, ".ex_rs"}, 32'(bus.ex_rs), 32'(m_rs));
            chk({tg, ".ex_rt"}, 32'(bus.ex_rt), 32'(m_rt));
            chk({tg, ".ex_wa"}, 32'(bus.ex_wa), 32'(m_wa));
            chk({tg, ".ex_rd1"}, bus.ex_rd1, m_rd1);
            chk({tg, ".ex_rd2"}, bus.ex_rd2, m_rd2);
            chk({tg, ".ex_imm"}, bus.ex_imm, m_imm);
        end
    endtask

    // Inputs are already applied; check id_stall, advance one edge, check EX.
    task automatic step(input string tg);
        bit lu;
        bit exp_stall;
        #1;
        lu        = model_lu();
        exp_stall = bus.ex_hold || (lu && !bus.flush);
        chk({tg, ".id_stall"}, 32'(bus.id_stall), 32'(exp_stall));
        if (bus.flush) begin
            model_kill();
        end else if (bus.ex_hold) begin
            // EX keeps its contents
        end else if (lu) begin
            model_kill();
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end else begin
            m_valid    = bus.id_valid;
            m_regwrite = bus.id_valid && bus.regwrite;
            m_memread  = bus.id_valid && bus.memread;
            m_memwrite = bus.id_valid && bus.memwrite;
            m_alusrc   = bus.id_valid && bus.alusrc;
            m_alu_op   = bus.alu_op;
            m_rs = bus.rs; m_rt = bus.rt; m_wa = bus.wa;
            m_rd1 = bus.rd1; m_rd2 = bus.rd2; m_imm = bus.imm;
        end
        @(posedge clk);
        #1;
        compare_all(tg);
    endtask

    task automatic instr(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] wa, input bit ut, input bit rw, input bit mr,
                         input logic [31:0] r1, input logic [31:0] r2);
        bus.id_valid = v; bus.rs = rs; bus.rt = rt; bus.wa = wa; bus.uses_rt = ut;
        bus.regwrite = rw; bus.memread = mr; bus.memwrite = 1'b0; bus.alusrc = 1'b1;
        bus.alu_op = 4'h3; bus.rd1 = r1; bus.rd2 = r2; bus.imm = r1 ^ r2;
        bus.flush = 1'b0; bus.ex_hold = 1'b0;
    endtask

    initial begin
        bit          m4_load;
        int unsigned m4_cnt;
        model_reset();
        instr(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        bus4.id_valid = 1'b1; bus4.rs = 5'd8; bus4.rt = 5'd0; bus4.wa = 5'd8;
        bus4.uses_rt = 1'b0; bus4.regwrite = 1'b1; bus4.memread = 1'b1;
        bus4.memwrite = 1'b0; bus4.alusrc = 1'b0; bus4.alu_op = 4'h0;
        bus4.rd1 = '0; bus4.rd2 = '0; bus4.imm = '0; bus4.flush = 1'b0; bus4.ex_hold = 1'b1;

        // Reset state, and id_stall suppressed while in reset
        #12;
        compare_all("reset");
        chk("reset.ex_rd1", bus.ex_rd1, 32'h0);
        chk("reset.ex_wa", 32'(bus.ex_wa), 32'h0);
        bus.ex_hold = 1'b1;
        #1;
        chk("reset.id_stall_hold", 32'(bus.id_stall), 32'h0);
        bus.ex_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Normal capture
        instr(1, 5'd1, 5'd2, 5'd5, 1, 1, 0, 32'h11, 32'h22);
        step("normal");
        chk("normal.valid_k", 32'(bus.ex_valid), 32'h1);
        chk("normal.rd1_k", bus.ex_rd1, 32'h11);
        chk("normal.rd2_k", bus.ex_rd2, 32'h22);
        chk("normal.wa_k", 32'(bus.ex_wa), 32'd5);

        // Load-use on rs: one bubble, then capture
        instr(1, 5'd0, 5'd0, 5'd8, 0, 1, 1, 32'h1, 32'h2);
        step("lw8");
        instr(1, 5'd8, 5'd0, 5'd3, 0, 1, 0, 32'h33, 32'h44);
        step("lu_rs");
        chk("lu_rs.bubble_k", 32'(bus.ex_valid), 32'h0);
        chk("lu_rs.count_k", bus.stall_count, 32'd1);
        step("lu_rs_cap");
        chk("lu_rs_cap.wa_k", 32'(bus.ex_wa), 32'd3);

        // rt gated by uses_rt; destination 0 never stalls
        instr(1, 5'd0, 5'd0, 5'd9, 0, 1, 1, 32'h5, 32'h6);
        step("lw9a");
        instr(1, 5'd1, 5'd9, 5'd4, 0, 1, 0, 32'h7, 32'h8);
        step("rt_nouse");
        chk("rt_nouse.count_k", bus.stall_count, 32'd1);
        instr(1, 5'd0, 5'd0, 5'd9, 0, 1, 1, 32'h5, 32'h6);
        step("lw9b");
        instr(1, 5'd1, 5'd9, 5'd4, 1, 1, 0, 32'h7, 32'h8);
        step("rt_use");
        chk("rt_use.count_k", bus.stall_count, 32'd2);
        step("rt_use_cap");
        instr(1, 5'd0, 5'd0, 5'd0, 0, 1, 1, 32'h9, 32'hA);
        step("lw0");
        instr(1, 5'd0, 5'd0, 5'd6, 1, 1, 0, 32'hB, 32'hC);
        step("wa0");
        chk("wa0.count_k", bus.stall_count, 32'd2);

        // Flush beats hold
        instr(1, 5'd1, 5'd2, 5'd7, 1, 1, 1, 32'hD, 32'hE);
        bus.memwrite = 1'b1; bus.flush = 1'b1; bus.ex_hold = 1'b1;
        step("flush_hold");
        chk("flush_hold.valid_k", 32'(bus.ex_valid), 32'h0);
        chk("flush_hold.ctl_k", 32'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite}), 32'h0);

        // Hold for three cycles
        instr(1, 5'd3, 5'd4, 5'd10, 1, 1, 0, 32'hAA, 32'hBB);
        step("pre_hold");
        instr(1, 5'd11, 5'd12, 5'd13, 1, 0, 1, 32'hCC, 32'hDD);
        bus.ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("hold%0d", i));
        chk("hold.rd1_k", bus.ex_rd1, 32'hAA);
        chk("hold.wa_k", 32'(bus.ex_wa), 32'd10);

        // Random traffic with small register indices to provoke hazards
        for (int i = 0; i < 400; i++) begin
            bus.id_valid = ($urandom_range(0, 7) != 0);
            bus.rs = 5'($urandom_range(0, 3)); bus.rt = 5'($urandom_range(0, 3));
            bus.wa = 5'($urandom_range(0, 3)); bus.uses_rt = 1'($urandom);
            bus.regwrite = 1'($urandom); bus.memread = 1'($urandom);
            bus.memwrite = 1'($urandom); bus.alusrc = 1'($urandom);
            bus.alu_op = 4'($urandom); bus.rd1 = $urandom; bus.rd2 = $urandom;
            bus.imm = $urandom;
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.ex_hold = ($urandom_range(0, 7) == 0);
            step($sformatf("rnd%0d", i));
        end

        // Reset asserted between edges during a load-use bubble
        instr(1, 5'd0, 5'd0, 5'd8, 0, 1, 1, 32'h1, 32'h2);
        step("mid_lw");
        instr(1, 5'd8, 5'd0, 5'd3, 0, 1, 0, 32'h3, 32'h4);
        step("mid_bubble");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("mid_rst");
        chk("mid_rst.ex_wa", 32'(bus.ex_wa), 32'h0);
        chk("mid_rst.id_stall", 32'(bus.id_stall), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        instr(1, 5'd1, 5'd2, 5'd12, 1, 1, 0, 32'h55, 32'h66);
        step("post_rst");

        // Narrow counter: back-to-back dependent loads saturate at 15
        m4_load = 0;
        m4_cnt  = 0;
        @(negedge clk);
        bus4.ex_hold = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            chk($sformatf("sat%0d.id_stall", i), 32'(bus4.id_stall), 32'(m4_load));
            if (m4_load) begin
                m4_load = 0;
                if (m4_cnt < 15) m4_cnt++;
            end else begin
                m4_load = 1;
            end
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d.count", i), 32'(bus4.stall_count), m4_cnt);
        end
        chk("sat.final", 32'(bus4.stall_count), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
